// File: rtl/instr_fetch_if.sv
// Fetch-side bus between the PC block, the fetch unit and decode.
// instr is offered while instr_valid=1 and stays stable until a cycle with instr_ready=1 (and flush=0) accepts it.
interface instr_fetch_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] pc;
  logic              pc_en;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_fault;
  logic              flush;

  modport master (
    input  pc, instr_ready, flush,
    output pc_en, instr, instr_valid, fetch_fault
  );

  modport slave (
    output pc, instr_ready, flush,
    input  pc_en, instr, instr_valid, fetch_fault
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program memory plus a READ/HOLD fetch sequencer that drives pc_en back to the PC block.
// Optional fetch/fault counters are enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int          ADDR_W    = 11,
  parameter int          MEM_WORDS = 512,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_fetch_if.master     bus,
  input  logic              ld_we,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_err,
  output logic [1:0]        dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       fault_count
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state, next_state;

  logic [31:0]       mem [MEM_WORDS];
  logic [31:0]       rd_q;
  logic              fault_q;
  logic [ADDR_W-3:0] rd_idx;
  logic              rd_fault;
  logic              ld_ok;
  logic              pc_en;
  logic              valid;

  assign rd_idx   = bus.pc[ADDR_W-1:2];
  assign rd_fault = (bus.pc[1:0] != 2'b00) || (32'(rd_idx) >= 32'(MEM_WORDS));
  assign ld_ok    = ld_we && (state == S_IDLE) && (32'(ld_addr) < 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ld_err <= 1'b0;
    end else begin
      state  <= next_state;
      ld_err <= ld_we && (state != S_IDLE);
    end
  end

  // Memory and read register are never reset; the HOLD-state gating below hides stale data.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
    if (state == S_READ) begin
      fault_q <= rd_fault;
      rd_q    <= rd_fault ? NOP_INSTR : mem[rd_idx[IDX_W-1:0]];
    end
  end

  always_comb begin
    next_state = state;
    pc_en      = 1'b0;
    valid      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_READ;
      end
      S_READ: begin
        // A redirect here re-reads at the new target; the read registered this cycle is dropped.
        pc_en      = bus.flush;
        next_state = bus.flush ? S_READ : S_HOLD;
      end
      S_HOLD: begin
        valid = 1'b1;
        pc_en = bus.flush | bus.instr_ready;
        if (bus.flush || bus.instr_ready) next_state = S_READ;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.instr_valid = valid;
  assign bus.fetch_fault = valid & fault_q;
  assign bus.instr       = (valid && !fault_q) ? rd_q : NOP_INSTR;
  assign dbg_state       = state;

`ifdef FETCH_PERF_CNT_EN
  logic accept;
  assign accept = (state == S_HOLD) && bus.instr_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      fault_count <= '0;
    end else if (accept) begin
      if (!fault_q) begin
        fetch_count <= fetch_count + 32'd1;
      end else if (fault_count != 16'hFFFF) begin
        fault_count <= fault_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC model, fetch scoreboard, load/flush/fault/reset scenarios.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ld_we;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] fault_count;
`endif

  instr_fetch_if #(.ADDR_W(11)) bus ();

  instr_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_err    (ld_err),
    .dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .fault_count (fault_count)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model_mem [512];
  logic [10:0] flush_pc;

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model_fetch(input logic [10:0] a);
    if (a[1:0] != 2'b00) return {1'b1, NOP};
    return {1'b0, model_mem[a[10:2]]};
  endfunction

  // One clock: check pc_en, score accepted instructions, then advance the PC model.
  task automatic cycle(input logic exp_en);
    logic        en;
    logic        redirect;
    logic [32:0] got;
    logic [32:0] want;
    @(negedge clk);
    en       = bus.pc_en;
    redirect = bus.flush;
    check("pc_en", 64'(en), 64'(exp_en));
    if (bus.instr_valid && bus.instr_ready && !bus.flush) begin
      got = {bus.fetch_fault, bus.instr};
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_pop++;
        check("fetch", 64'(got), 64'(want));
      end
    end
    @(posedge clk);
    #1;
    if (en) begin
      if (redirect) begin
        exp_q.delete();
        bus.pc = flush_pc;
      end else begin
        bus.pc = bus.pc + 11'd4;
      end
      exp_q.push_back(model_fetch(bus.pc));
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    ld_we           = 1'b0;
    ld_addr         = '0;
    ld_data         = '0;
    bus.pc          = '0;
    bus.instr_ready = 1'b0;
    bus.flush       = 1'b0;
    flush_pc        = '0;

    // reset state
    #12;
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'(NOP));
    check("rst_fault", 64'(bus.fetch_fault), 64'd0);
    check("rst_ld_err", 64'(ld_err), 64'd0);
    check("rst_pc_en", 64'(bus.pc_en), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // program load in IDLE
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       ld_data = 32'h0050_0093;
        1:       ld_data = 32'h0010_8113;
        2:       ld_data = 32'h0000_006F;
        16:      ld_data = 32'h00A0_0193;
        default: ld_data = $urandom();
      endcase
      ld_we        = 1'b1;
      ld_addr      = 9'(i);
      model_mem[i] = ld_data;
      @(posedge clk);
      #1;
    end
    ld_we = 1'b0;
    check("load_idle_no_err", 64'(ld_err), 64'd0);

    // sequential fetch pc=0,4,8 with instr_ready high
    bus.instr_ready = 1'b1;
    start = 1'b1;
    exp_q.push_back(model_fetch(bus.pc));
    cycle(1'b0);
    start = 1'b0;
    cycle(1'b0);
    check("hold_valid", 64'(bus.instr_valid), 64'd1);
    cycle(1'b1);
    cycle(1'b0);

    // stall at pc=4
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(bus.instr_valid), 64'd1);
      check("stall_instr", 64'(bus.instr), 64'h0010_8113);
      cycle(1'b0);
    end
    bus.instr_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_3", 64'(fetch_count), 64'd3);
    check("fault_count_0", 64'(fault_count), 64'd0);
`endif

    // redirect from READ to misaligned pc=6
    flush_pc  = 11'h006;
    bus.flush = 1'b1;
    cycle(1'b1);
    bus.flush = 1'b0;
    check("flush_read_valid", 64'(bus.instr_valid), 64'd0);
    cycle(1'b0);
    check("fault_valid", 64'(bus.instr_valid), 64'd1);
    check("fault_flag", 64'(bus.fetch_fault), 64'd1);
    check("fault_instr", 64'(bus.instr), 64'(NOP));
    cycle(1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("fault_count_1", 64'(fault_count), 64'd1);
    check("fetch_count_kept", 64'(fetch_count), 64'd3);
`endif

    // flush beats instr_ready in HOLD (pc=10 fault pending)
    cycle(1'b0);
    flush_pc  = 11'h040;
    bus.flush = 1'b1;
    cycle(1'b1);
    bus.flush = 1'b0;
    check("flush_hold_valid", 64'(bus.instr_valid), 64'd0);
    check("flush_hold_fault", 64'(bus.fetch_fault), 64'd0);
    check("flush_hold_instr", 64'(bus.instr), 64'(NOP));
    cycle(1'b0);
    cycle(1'b1);
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count_4", 64'(fetch_count), 64'd4);
    check("fault_count_still_1", 64'(fault_count), 64'd1);
`endif

    // load attempt while busy
    bus.instr_ready = 1'b0;
    cycle(1'b0);
    ld_we   = 1'b1;
    ld_addr = 9'd0;
    ld_data = 32'hDEAD_BEEF;
    cycle(1'b0);
    ld_we = 1'b0;
    check("ld_err_pulse", 64'(ld_err), 64'd1);
    cycle(1'b0);
    check("ld_err_clear", 64'(ld_err), 64'd0);

    // reset in HOLD with a valid instruction
    check("pre_rst_valid", 64'(bus.instr_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.instr_valid), 64'd0);
    check("midrst_instr", 64'(bus.instr), 64'(NOP));
    check("midrst_pc_en", 64'(bus.pc_en), 64'd0);
    check("midrst_fault", 64'(bus.fetch_fault), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("midrst_fetch_count", 64'(fetch_count), 64'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    bus.pc = '0;
    @(posedge clk);
    #1;

    // flush in IDLE is ignored, nothing fetched until start
    bus.instr_ready = 1'b1;
    bus.flush       = 1'b1;
    cycle(1'b0);
    bus.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0);
      check("idle_no_fetch", 64'(bus.instr_valid), 64'd0);
    end

    // refetch pc=0: memory must be unchanged by the rejected load
    start = 1'b1;
    exp_q.push_back(model_fetch(bus.pc));
    cycle(1'b0);
    start = 1'b0;
    cycle(1'b0);
    check("refetch_instr", 64'(bus.instr), 64'h0050_0093);
    cycle(1'b1);

    check("pop_count", 64'(n_pop), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
